// File: rtl/char_reg_pkg.sv
// Shared constants and types for the character-recognition picture path.
package char_reg_pkg;

    localparam int unsigned IMG_W        = 28;
    localparam int unsigned IMG_H        = 28;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned PIC_ADDR_W   = 10;
    localparam int unsigned FRAME_PIXELS = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rd_state_t;

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry FIFO that holds tagged pixels returned from the picture RAM.
module pix_skid_buf #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // The reader's credit rule must make both of these impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && r_count == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && r_count == 2'd0));

endmodule

// File: rtl/pic_ram_reader.sv
// Frame-read sequencer: walks the picture RAM in raster order and streams tagged pixels.
module pic_ram_reader #(
    parameter int unsigned IMG_W     = char_reg_pkg::IMG_W,
    parameter int unsigned IMG_H     = char_reg_pkg::IMG_H,
    parameter int unsigned ADDR_W    = char_reg_pkg::PIC_ADDR_W,
    parameter int unsigned DATA_W    = char_reg_pkg::PIX_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic [4:0]        pix_row,
    output logic [4:0]        pix_col,
    output logic              pix_last
);

    import char_reg_pkg::*;

    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned ENT_W = DATA_W + 11;

    rd_state_t         r_state;
    rd_state_t         w_state_next;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic              r_in_flight;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [4:0]        r_tag_row;
    logic [4:0]        r_tag_col;

    logic [ENT_W-1:0]  w_push_ent;
    logic [ENT_W-1:0]  w_head;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic              w_valid;
    logic              w_pop;
    logic              w_issue;
    logic              w_start_acc;
    logic              w_tag_last;
    logic              w_head_last;
    logic              w_last_hs;

    assign w_valid     = (w_count != 2'd0);
    assign w_pop       = w_valid & pix_ready;
    assign w_head_last = w_head[ENT_W-1];
    assign w_last_hs   = w_pop & w_head_last;
    assign w_start_acc = (r_state == IDLE) & start;

    // Credit counts the beat leaving this cycle so a full-rate stream never bubbles.
    assign w_occ   = {2'b00, r_in_flight} + {1'b0, w_count};
    assign w_issue = (r_state == RUN) && (r_issue_cnt < CNT_W'(NPIX))
                     && (w_occ < (3'd2 + {2'b00, w_pop}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last_hs) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Row/col tags advance as pixels enter the FIFO, which is also handshake order.
    assign w_tag_last = (r_tag_row == 5'(IMG_H - 1)) && (r_tag_col == 5'(IMG_W - 1));
    assign w_push_ent = {w_tag_last, r_tag_row, r_tag_col, ram_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_in_flight <= 1'b0;
            r_ram_addr  <= ADDR_W'(BASE_ADDR);
            r_tag_row   <= '0;
            r_tag_col   <= '0;
        end else begin
            r_in_flight <= w_issue;
            if (w_start_acc) begin
                r_issue_cnt <= '0;
                r_ram_addr  <= ADDR_W'(BASE_ADDR);
                r_tag_row   <= '0;
                r_tag_col   <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                    if (r_issue_cnt != CNT_W'(NPIX - 1)) begin
                        r_ram_addr <= r_ram_addr + ADDR_W'(1);
                    end
                end
                if (r_in_flight) begin
                    if (r_tag_col == 5'(IMG_W - 1)) begin
                        r_tag_col <= '0;
                        r_tag_row <= r_tag_row + 5'd1;
                    end else begin
                        r_tag_col <= r_tag_col + 5'd1;
                    end
                end
            end
        end
    end

    pix_skid_buf #(
        .WIDTH(ENT_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_in_flight),
        .i_pop  (w_pop),
        .i_data (w_push_ent),
        .o_head (w_head),
        .o_count(w_count)
    );

    assign ram_addr  = r_ram_addr;
    assign pix_valid = w_valid;
    assign pix_data  = w_head[DATA_W-1:0];
    assign pix_col   = w_head[DATA_W +: 5];
    assign pix_row   = w_head[DATA_W+5 +: 5];
    assign pix_last  = w_valid & w_head_last;

endmodule

// File: tb/tb_pic_ram_reader.sv
// Scoreboard bench for pic_ram_reader against a 1-cycle sync RAM holding mem[a]=a[7:0].
module tb_pic_ram_reader;

    localparam int NPIX = 784;

    typedef struct packed {
        logic [7:0] d;
        logic [4:0] r;
        logic [4:0] c;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pix_valid, pix_last;
    logic       pix_ready = 1'b0;
    logic [9:0] ram_addr;
    logic [7:0] ram_data = '0;
    logic [7:0] pix_data;
    logic [4:0] pix_row, pix_col;

    logic       start_b = 1'b0;
    logic       pix_ready_b = 1'b1;
    logic       busy_b, done_b, pix_valid_b, pix_last_b;
    logic [9:0] ram_addr_b;
    logic [7:0] ram_data_b = '0;
    logic [7:0] pix_data_b;
    logic [4:0] pix_row_b, pix_col_b;

    beat_t q[$];
    beat_t qb[$];
    int checks = 0;
    int failures = 0;
    int acc = 0;
    int acc_base = 0;
    int done_cnt = 0;
    int done_cnt_b = 0;
    int first_addr_b = -1;
    int max_addr_b = 0;
    int rdy_mode = 1;

    pic_ram_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_data(ram_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .pix_row(pix_row),
        .pix_col(pix_col), .pix_last(pix_last)
    );

    pic_ram_reader #(.BASE_ADDR(100)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b), .pix_valid(pix_valid_b),
        .pix_ready(pix_ready_b), .pix_data(pix_data_b), .pix_row(pix_row_b),
        .pix_col(pix_col_b), .pix_last(pix_last_b)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        ram_data   <= ram_addr[7:0];
        ram_data_b <= ram_addr_b[7:0];
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       pix_ready = 1'b0;
            1:       pix_ready = 1'b1;
            default: pix_ready = ~pix_ready;
        endcase
    end

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int base, input bit to_b);
        for (int k = 0; k < NPIX; k++) begin
            beat_t e;
            e.d = 8'(base + k);
            e.r = 5'(k / 28);
            e.c = 5'(k % 28);
            e.l = (k == NPIX - 1);
            if (to_b) qb.push_back(e);
            else      q.push_back(e);
        end
    endtask

    // Monitor for the BASE_ADDR=0 instance.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (busy)
                chk("addr_ahead", int'(ram_addr) <= (acc - acc_base) + 2,
                    int'(ram_addr), (acc - acc_base) + 2);
            if (done) done_cnt++;
            if (pix_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1'b0, int'(pix_data), -1);
                end else begin
                    chk("pix_data", pix_data == q[0].d, int'(pix_data), int'(q[0].d));
                    chk("pix_row",  pix_row  == q[0].r, int'(pix_row),  int'(q[0].r));
                    chk("pix_col",  pix_col  == q[0].c, int'(pix_col),  int'(q[0].c));
                    chk("pix_last", pix_last == q[0].l, int'(pix_last), int'(q[0].l));
                    if (pix_ready) begin
                        void'(q.pop_front());
                        acc++;
                    end
                end
            end else if (pix_last) begin
                chk("pix_last_idle", 1'b0, 1, 0);
            end
        end
    end

    // Monitor for the BASE_ADDR=100 instance (always ready).
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (busy_b) begin
                if (first_addr_b < 0) first_addr_b = int'(ram_addr_b);
                if (int'(ram_addr_b) > max_addr_b) max_addr_b = int'(ram_addr_b);
            end
            if (done_b) done_cnt_b++;
            if (pix_valid_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_beat", 1'b0, int'(pix_data_b), -1);
                end else begin
                    chk("b_pix_data", pix_data_b == qb[0].d, int'(pix_data_b), int'(qb[0].d));
                    chk("b_pix_row",  pix_row_b  == qb[0].r, int'(pix_row_b),  int'(qb[0].r));
                    chk("b_pix_col",  pix_col_b  == qb[0].c, int'(pix_col_b),  int'(qb[0].c));
                    chk("b_pix_last", pix_last_b == qb[0].l, int'(pix_last_b), int'(qb[0].l));
                    void'(qb.pop_front());
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk("done_seen", done, n, budget);
        if (done) begin
            chk("busy_at_done", busy == 1'b0, int'(busy), 0);
            @(negedge clk);
            chk("done_pulse", done == 1'b0, int'(done), 0);
        end
    endtask

    task automatic frame_end(input int d0);
        chk("sb_empty", q.size() == 0, q.size(), 0);
        chk("done_count", done_cnt - d0 == 1, done_cnt - d0, 1);
    endtask

    task automatic wait_beats(input int target);
        int i;
        for (i = 0; i < 2000 && (acc - acc_base) < target; i++) begin
            @(negedge clk);
            #1;
        end
        chk("beats_reached", (acc - acc_base) >= target, acc - acc_base, target);
    endtask

    initial begin
        int n;
        int d0;
        repeat (3) @(negedge clk);
        chk("rst_busy",      busy == 1'b0,       int'(busy), 0);
        chk("rst_done",      done == 1'b0,       int'(done), 0);
        chk("rst_valid",     pix_valid == 1'b0,  int'(pix_valid), 0);
        chk("rst_last",      pix_last == 1'b0,   int'(pix_last), 0);
        chk("rst_addr",      ram_addr == 10'd0,  int'(ram_addr), 0);
        chk("rst_addr_b",    ram_addr_b == 10'd100, int'(ram_addr_b), 100);
        chk("rst_data",      pix_data == 8'd0,   int'(pix_data), 0);
        chk("rst_rowcol",    {pix_row, pix_col} == 10'd0, int'({pix_row, pix_col}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full rate, fill latency and cycle-exact completion.
        rdy_mode = 1;
        push_frame(0, 1'b0);
        acc_base = acc;
        d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        chk("t1_busy_after_start", busy == 1'b1, int'(busy), 1);
        chk("t1_valid_c1", pix_valid == 1'b0, int'(pix_valid), 0);
        @(negedge clk);
        chk("t1_valid_c2", pix_valid == 1'b0, int'(pix_valid), 0);
        @(negedge clk);
        chk("t1_first_valid", pix_valid == 1'b1, int'(pix_valid), 1);
        wait_done(900, n);
        chk("t1_rate", n == NPIX, n, NPIX);
        frame_end(d0);

        // Alternating ready.
        rdy_mode = 2;
        push_frame(0, 1'b0);
        acc_base = acc;
        d0 = done_cnt;
        pulse_start();
        wait_done(3000, n);
        frame_end(d0);

        // Long stall straight after start.
        rdy_mode = 0;
        @(posedge clk);
        push_frame(0, 1'b0);
        acc_base = acc;
        d0 = done_cnt;
        pulse_start();
        repeat (50) @(negedge clk);
        chk("t3_two_reads", ram_addr == 10'd2, int'(ram_addr), 2);
        chk("t3_valid", pix_valid == 1'b1, int'(pix_valid), 1);
        chk("t3_data0", pix_data == 8'd0, int'(pix_data), 0);
        chk("t3_busy", busy == 1'b1, int'(busy), 1);
        rdy_mode = 1;
        wait_done(1000, n);
        frame_end(d0);

        // Starts while busy / at done ignored; start one cycle after done accepted.
        rdy_mode = 1;
        push_frame(0, 1'b0);
        acc_base = acc;
        d0 = done_cnt;
        pulse_start();
        wait_beats(100);
        pulse_start();
        @(negedge clk);
        chk("t4_busy_mid", busy == 1'b1, int'(busy), 1);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done_seen", done, n, 1000);
        start = 1'b1;
        @(negedge clk);
        chk("t4_start_at_done_ignored", busy == 1'b0, int'(busy), 0);
        chk("t4_done_low", done == 1'b0, int'(done), 0);
        frame_end(d0);
        push_frame(0, 1'b0);
        acc_base = acc;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_restart", busy == 1'b1, int'(busy), 1);
        chk("t4_addr0", ram_addr == 10'd0, int'(ram_addr), 0);
        wait_done(1000, n);
        frame_end(d0);

        // Reset mid-frame.
        rdy_mode = 1;
        push_frame(0, 1'b0);
        acc_base = acc;
        d0 = done_cnt;
        pulse_start();
        wait_beats(400);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_busy", busy == 1'b0, int'(busy), 0);
        chk("t5_done", done == 1'b0, int'(done), 0);
        chk("t5_valid", pix_valid == 1'b0, int'(pix_valid), 0);
        chk("t5_last", pix_last == 1'b0, int'(pix_last), 0);
        chk("t5_addr", ram_addr == 10'd0, int'(ram_addr), 0);
        chk("t5_data", pix_data == 8'd0, int'(pix_data), 0);
        chk("t5_row", pix_row == 5'd0, int'(pix_row), 0);
        chk("t5_col", pix_col == 5'd0, int'(pix_col), 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t5_start_in_rst", busy == 1'b0, int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("t5_no_done", done_cnt == d0, done_cnt, d0);
        chk("t5_idle_valid", pix_valid == 1'b0, int'(pix_valid), 0);
        push_frame(0, 1'b0);
        acc_base = acc;
        d0 = done_cnt;
        pulse_start();
        wait_done(1000, n);
        frame_end(d0);

        // Non-zero base address.
        push_frame(100, 1'b1);
        d0 = done_cnt_b;
        @(posedge clk);
        #1;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_done_seen", done_b, n, 1000);
        @(negedge clk);
        chk("t6_first_addr", first_addr_b == 100, first_addr_b, 100);
        chk("t6_last_addr", max_addr_b == 883, max_addr_b, 883);
        chk("t6_sb_empty", qb.size() == 0, qb.size(), 0);
        chk("t6_done_count", done_cnt_b - d0 == 1, done_cnt_b - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
